// File: rtl/multi_cycle_ctrl_if.sv
// Datapath-facing bundle of the multi-cycle controller: IR opcode, ALU flags and memory ready in,
// datapath enables, mux selects, ALU opcode, state and retire count out.
interface multi_cycle_ctrl_if #(
    parameter int OP_W    = 6,
    parameter int ALUOP_W = 3,
    parameter int CNT_W   = 32
);
    logic [OP_W-1:0]    Opcode;
    logic               zero;
    logic               sign;
    logic               mem_ready;

    logic               PCWre;
    logic               IRWre;
    logic               RegWre;
    logic [1:0]         RegDst;
    logic               WrRegDSrc;
    logic               ALUSrcA;
    logic               ALUSrcB;
    logic               DBDataSrc;
    logic               ExtSel;
    logic [1:0]         PCSrc;
    logic [ALUOP_W-1:0] ALUOp;
    logic               nRD;
    logic               nWR;
    logic [2:0]         state;
    logic               halted;
    logic [CNT_W-1:0]   instr_count;

    // datapath / IR side
    modport master (
        output Opcode, zero, sign, mem_ready,
        input  PCWre, IRWre, RegWre, RegDst, WrRegDSrc, ALUSrcA, ALUSrcB,
               DBDataSrc, ExtSel, PCSrc, ALUOp, nRD, nWR, state, halted, instr_count
    );

    // controller side
    modport slave (
        input  Opcode, zero, sign, mem_ready,
        output PCWre, IRWre, RegWre, RegDst, WrRegDSrc, ALUSrcA, ALUSrcB,
               DBDataSrc, ExtSel, PCSrc, ALUOp, nRD, nWR, state, halted, instr_count
    );
endinterface

// File: rtl/multi_cycle_ctrl.sv
// Multi-cycle CPU control FSM (IF/ID/EXE/MEM/WB) driving datapath controls and a retire counter.
// Controls are combinational from state and opcode; IF and MEM stall while memory is not ready.
module multi_cycle_ctrl #(
    parameter int OP_W    = 6,
    parameter int ALUOP_W = 3,
    parameter int WAIT_EN = 1,
    parameter int CNT_W   = 32
) (
    input  logic             CLK,
    input  logic             Reset,
    multi_cycle_ctrl_if.slave bus
);

    localparam logic [OP_W-1:0] OP_ADD   = OP_W'(6'b000000);
    localparam logic [OP_W-1:0] OP_SUB   = OP_W'(6'b000001);
    localparam logic [OP_W-1:0] OP_ADDIU = OP_W'(6'b000010);
    localparam logic [OP_W-1:0] OP_ANDI  = OP_W'(6'b010000);
    localparam logic [OP_W-1:0] OP_AND   = OP_W'(6'b010001);
    localparam logic [OP_W-1:0] OP_ORI   = OP_W'(6'b010010);
    localparam logic [OP_W-1:0] OP_OR    = OP_W'(6'b010011);
    localparam logic [OP_W-1:0] OP_SLL   = OP_W'(6'b011000);
    localparam logic [OP_W-1:0] OP_SLTI  = OP_W'(6'b011100);
    localparam logic [OP_W-1:0] OP_SW    = OP_W'(6'b110000);
    localparam logic [OP_W-1:0] OP_LW    = OP_W'(6'b110001);
    localparam logic [OP_W-1:0] OP_BEQ   = OP_W'(6'b110100);
    localparam logic [OP_W-1:0] OP_BNE   = OP_W'(6'b110101);
    localparam logic [OP_W-1:0] OP_BLTZ  = OP_W'(6'b110110);
    localparam logic [OP_W-1:0] OP_J     = OP_W'(6'b111000);
    localparam logic [OP_W-1:0] OP_JR    = OP_W'(6'b111001);
    localparam logic [OP_W-1:0] OP_JAL   = OP_W'(6'b111010);
    localparam logic [OP_W-1:0] OP_HALT  = OP_W'(6'b111111);

    localparam logic [ALUOP_W-1:0] ALU_ADD = ALUOP_W'(3'b000);
    localparam logic [ALUOP_W-1:0] ALU_SUB = ALUOP_W'(3'b001);
    localparam logic [ALUOP_W-1:0] ALU_SLL = ALUOP_W'(3'b010);
    localparam logic [ALUOP_W-1:0] ALU_OR  = ALUOP_W'(3'b011);
    localparam logic [ALUOP_W-1:0] ALU_AND = ALUOP_W'(3'b100);
    localparam logic [ALUOP_W-1:0] ALU_SLT = ALUOP_W'(3'b101);

    // All eight 3-bit codes are taken by the working states, so HALT lives in bit 3;
    // the 3-bit state port then reads 000 in HALT and halted tells it apart from IF.
    typedef enum logic [3:0] {
        S_IF     = 4'b0000,
        S_ID     = 4'b0001,
        S_EXE_LS = 4'b0010,
        S_MEM    = 4'b0011,
        S_WB_LD  = 4'b0100,
        S_EXE_BR = 4'b0101,
        S_EXE_AL = 4'b0110,
        S_WB_AL  = 4'b0111,
        S_HALT   = 4'b1000
    } state_e;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic mem_rdy;
    assign mem_rdy = (WAIT_EN == 0) ? 1'b1 : bus.mem_ready;

    // opcode decode
    logic               is_alu, is_rtype, is_br, is_ls, is_sw, is_jmp, is_halt;
    logic [ALUOP_W-1:0] dec_alu_op;
    logic               dec_src_a, dec_src_b, dec_ext;
    logic               br_taken;

    always_comb begin
        is_alu     = 1'b0;
        is_rtype   = 1'b0;
        is_br      = 1'b0;
        is_ls      = 1'b0;
        is_sw      = 1'b0;
        is_jmp     = 1'b0;
        is_halt    = 1'b0;
        dec_alu_op = ALU_ADD;
        dec_src_a  = 1'b0;
        dec_src_b  = 1'b0;
        dec_ext    = 1'b0;
        case (bus.Opcode)
            OP_ADD:   begin is_alu = 1'b1; is_rtype = 1'b1; end
            OP_SUB:   begin is_alu = 1'b1; is_rtype = 1'b1; dec_alu_op = ALU_SUB; end
            OP_ADDIU: begin is_alu = 1'b1; dec_src_b = 1'b1; dec_ext = 1'b1; end
            OP_ANDI:  begin is_alu = 1'b1; dec_src_b = 1'b1; dec_alu_op = ALU_AND; end
            OP_AND:   begin is_alu = 1'b1; is_rtype = 1'b1; dec_alu_op = ALU_AND; end
            OP_ORI:   begin is_alu = 1'b1; dec_src_b = 1'b1; dec_alu_op = ALU_OR; end
            OP_OR:    begin is_alu = 1'b1; is_rtype = 1'b1; dec_alu_op = ALU_OR; end
            OP_SLL:   begin is_alu = 1'b1; is_rtype = 1'b1; dec_alu_op = ALU_SLL; dec_src_a = 1'b1; end
            OP_SLTI:  begin is_alu = 1'b1; dec_src_b = 1'b1; dec_ext = 1'b1; dec_alu_op = ALU_SLT; end
            OP_SW:    begin is_ls = 1'b1; is_sw = 1'b1; end
            OP_LW:    is_ls   = 1'b1;
            OP_BEQ,
            OP_BNE,
            OP_BLTZ:  is_br   = 1'b1;
            OP_J,
            OP_JR,
            OP_JAL:   is_jmp  = 1'b1;
            OP_HALT:  is_halt = 1'b1;
            default:  ;
        endcase
    end

    assign br_taken = ((bus.Opcode == OP_BEQ)  &&  bus.zero) ||
                      ((bus.Opcode == OP_BNE)  && !bus.zero) ||
                      ((bus.Opcode == OP_BLTZ) &&  bus.sign);

    // next state and datapath controls
    logic               pc_wre, ir_wre, reg_wre, wr_src, src_a, src_b, db_src, ext_sel, n_rd, n_wr;
    logic [1:0]         reg_dst, pc_src;
    logic [ALUOP_W-1:0] alu_op;

    always_comb begin
        state_d = state_q;
        pc_wre  = 1'b0;
        ir_wre  = 1'b0;
        reg_wre = 1'b0;
        reg_dst = 2'b00;
        wr_src  = 1'b0;
        src_a   = 1'b0;
        src_b   = 1'b0;
        db_src  = 1'b0;
        ext_sel = 1'b0;
        pc_src  = 2'b00;
        alu_op  = ALU_ADD;
        n_rd    = 1'b1;
        n_wr    = 1'b1;
        case (state_q)
            S_IF: begin
                n_rd   = 1'b0;
                ir_wre = mem_rdy;
                if (mem_rdy) state_d = S_ID;
            end
            S_ID: begin
                if (is_jmp) begin
                    pc_wre  = 1'b1;
                    pc_src  = (bus.Opcode == OP_JR) ? 2'b10 : 2'b11;
                    reg_wre = (bus.Opcode == OP_JAL);
                    state_d = S_IF;
                end else if (is_halt) begin
                    state_d = S_HALT;
                end else if (is_br) begin
                    state_d = S_EXE_BR;
                end else if (is_ls) begin
                    state_d = S_EXE_LS;
                end else if (is_alu) begin
                    state_d = S_EXE_AL;
                end else begin
                    // undefined opcode retires as a NOP
                    pc_wre  = 1'b1;
                    state_d = S_IF;
                end
            end
            S_EXE_AL: begin
                alu_op  = dec_alu_op;
                src_a   = dec_src_a;
                src_b   = dec_src_b;
                ext_sel = dec_ext;
                state_d = S_WB_AL;
            end
            S_WB_AL: begin
                alu_op  = dec_alu_op;
                src_a   = dec_src_a;
                src_b   = dec_src_b;
                ext_sel = dec_ext;
                reg_wre = 1'b1;
                wr_src  = 1'b1;
                reg_dst = is_rtype ? 2'b10 : 2'b01;
                pc_wre  = 1'b1;
                state_d = S_IF;
            end
            S_EXE_BR: begin
                alu_op  = ALU_SUB;
                ext_sel = 1'b1;
                pc_src  = br_taken ? 2'b01 : 2'b00;
                pc_wre  = 1'b1;
                state_d = S_IF;
            end
            S_EXE_LS: begin
                alu_op  = ALU_ADD;
                src_b   = 1'b1;
                ext_sel = 1'b1;
                state_d = S_MEM;
            end
            S_MEM: begin
                if (is_sw) begin
                    n_wr   = 1'b0;
                    pc_wre = mem_rdy;
                    if (mem_rdy) state_d = S_IF;
                end else begin
                    n_rd = 1'b0;
                    if (mem_rdy) state_d = S_WB_LD;
                end
            end
            S_WB_LD: begin
                reg_wre = 1'b1;
                db_src  = 1'b1;
                reg_dst = 2'b01;
                wr_src  = 1'b1;
                pc_wre  = 1'b1;
                state_d = S_IF;
            end
            S_HALT: ;
            default: state_d = S_IF;
        endcase
    end

    assign cnt_d = pc_wre ? cnt_q + CNT_W'(1) : cnt_q;

    always_ff @(posedge CLK or negedge Reset) begin
        if (!Reset) begin
            state_q <= S_IF;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    assign bus.PCWre       = pc_wre;
    assign bus.IRWre       = ir_wre;
    assign bus.RegWre      = reg_wre;
    assign bus.RegDst      = reg_dst;
    assign bus.WrRegDSrc   = wr_src;
    assign bus.ALUSrcA     = src_a;
    assign bus.ALUSrcB     = src_b;
    assign bus.DBDataSrc   = db_src;
    assign bus.ExtSel      = ext_sel;
    assign bus.PCSrc       = pc_src;
    assign bus.ALUOp       = alu_op;
    assign bus.nRD         = n_rd;
    assign bus.nWR         = n_wr;
    assign bus.state       = state_q[2:0];
    assign bus.halted      = (state_q == S_HALT);
    assign bus.instr_count = cnt_q;

endmodule

// File: tb/tb_multi_cycle_ctrl.sv
// Bench for multi_cycle_ctrl: directed scenarios plus a randomized instruction stream
// checked against an instruction-level walk of the control rules.
`timescale 1ns/1ps
module tb_multi_cycle_ctrl;

    localparam logic [5:0] OP_ADD = 6'b000000, OP_SUB = 6'b000001, OP_ADDIU = 6'b000010;
    localparam logic [5:0] OP_ANDI = 6'b010000, OP_AND = 6'b010001, OP_ORI = 6'b010010;
    localparam logic [5:0] OP_OR = 6'b010011, OP_SLL = 6'b011000, OP_SLTI = 6'b011100;
    localparam logic [5:0] OP_SW = 6'b110000, OP_LW = 6'b110001, OP_BEQ = 6'b110100;
    localparam logic [5:0] OP_BNE = 6'b110101, OP_BLTZ = 6'b110110, OP_J = 6'b111000;
    localparam logic [5:0] OP_JR = 6'b111001, OP_JAL = 6'b111010, OP_HALT = 6'b111111;
    localparam logic [5:0] OP_NOP = 6'b100000;

    localparam logic [2:0] ST_IF = 3'b000, ST_ID = 3'b001, ST_EXE_AL = 3'b110, ST_EXE_BR = 3'b101;
    localparam logic [2:0] ST_EXE_LS = 3'b010, ST_MEM = 3'b011, ST_WB_AL = 3'b111, ST_WB_LD = 3'b100;

    logic       CLK = 1'b0;
    logic       Reset = 1'b0;
    logic [5:0] opcode = OP_NOP;
    logic       zero = 1'b0, sign = 1'b0, mem_ready = 1'b1;

    int          n_tests = 0;
    int          n_fail  = 0;
    int unsigned exp_cnt = 0;

    always #5 CLK = ~CLK;

    multi_cycle_ctrl_if #(.OP_W(6), .ALUOP_W(3), .CNT_W(32)) ifa ();
    multi_cycle_ctrl_if #(.OP_W(6), .ALUOP_W(3), .CNT_W(4))  ifb ();

    assign ifa.Opcode = opcode;  assign ifb.Opcode = opcode;
    assign ifa.zero = zero;      assign ifb.zero = zero;
    assign ifa.sign = sign;      assign ifb.sign = sign;
    assign ifa.mem_ready = mem_ready;
    assign ifb.mem_ready = mem_ready;

    multi_cycle_ctrl #(.OP_W(6), .ALUOP_W(3), .WAIT_EN(1), .CNT_W(32)) dut (
        .CLK(CLK), .Reset(Reset), .bus(ifa));
    multi_cycle_ctrl #(.OP_W(6), .ALUOP_W(3), .WAIT_EN(1), .CNT_W(4)) dut_w4 (
        .CLK(CLK), .Reset(Reset), .bus(ifb));

    typedef struct packed {
        logic [2:0] st;
        logic       hlt, pcw, irw, rgw;
        logic [1:0] rdst;
        logic       wrs, asa, asb, dbs, ext;
        logic [1:0] pcs;
        logic [2:0] aop;
        logic       nrd, nwr;
    } ov_t;

    function automatic ov_t observe();
        ov_t o;
        o.st = ifa.state;   o.hlt = ifa.halted;  o.pcw = ifa.PCWre;     o.irw = ifa.IRWre;
        o.rgw = ifa.RegWre; o.rdst = ifa.RegDst; o.wrs = ifa.WrRegDSrc; o.asa = ifa.ALUSrcA;
        o.asb = ifa.ALUSrcB; o.dbs = ifa.DBDataSrc; o.ext = ifa.ExtSel; o.pcs = ifa.PCSrc;
        o.aop = ifa.ALUOp;  o.nrd = ifa.nRD;     o.nwr = ifa.nWR;
        return o;
    endfunction

    // every control at its idle value in a given state
    function automatic ov_t base(input logic [2:0] st);
        ov_t e;
        e = '0;
        e.st = st; e.nrd = 1'b1; e.nwr = 1'b1;
        return e;
    endfunction

    function automatic ov_t if_vec(input logic rdy);
        ov_t e;
        e = base(ST_IF); e.nrd = 1'b0; e.irw = rdy;
        return e;
    endfunction

    // ALU-class instruction attributes straight from the opcode table
    function automatic ov_t with_alu(input ov_t e_in, input logic [5:0] op);
        ov_t e;
        e = e_in;
        case (op)
            OP_SUB:          e.aop = 3'b001;
            OP_SLL:          e.aop = 3'b010;
            OP_OR, OP_ORI:   e.aop = 3'b011;
            OP_AND, OP_ANDI: e.aop = 3'b100;
            OP_SLTI:         e.aop = 3'b101;
            default:         e.aop = 3'b000;
        endcase
        e.asa = (op == OP_SLL);
        e.asb = (op == OP_ADDIU) || (op == OP_ANDI) || (op == OP_ORI) || (op == OP_SLTI);
        e.ext = (op == OP_ADDIU) || (op == OP_SLTI);
        return e;
    endfunction

    function automatic logic is_rt(input logic [5:0] op);
        return (op == OP_ADD) || (op == OP_SUB) || (op == OP_AND) || (op == OP_OR) || (op == OP_SLL);
    endfunction
    function automatic logic is_alu(input logic [5:0] op);
        return is_rt(op) || (op == OP_ADDIU) || (op == OP_ANDI) || (op == OP_ORI) || (op == OP_SLTI);
    endfunction

    function automatic logic [5:0] pick_op(input int idx);
        case (idx)
            0: return OP_ADD;   1: return OP_SUB;   2: return OP_ADDIU; 3: return OP_ANDI;
            4: return OP_AND;   5: return OP_ORI;   6: return OP_OR;    7: return OP_SLL;
            8: return OP_SLTI;  9: return OP_SW;   10: return OP_LW;   11: return OP_BEQ;
            12: return OP_BNE; 13: return OP_BLTZ; 14: return OP_J;    15: return OP_JR;
            16: return OP_JAL;
            default: return 6'b100100 | 6'($urandom_range(0, 3));
        endcase
    endfunction

    task automatic next_cycle();
        @(posedge CLK);
        #1;
    endtask

    task automatic apply_reset();
        Reset = 1'b0; mem_ready = 1'b1; zero = 1'b0; sign = 1'b0;
        next_cycle();
        Reset = 1'b1;
        exp_cnt = 0;
    endtask

    task automatic test_reset();
        ov_t e, o;
        Reset = 1'b0; mem_ready = 1'b1; opcode = OP_LW;
        #1;
        e = if_vec(1'b1); o = observe(); n_tests++;
        if (o !== e) begin n_fail++; $display("FAIL reset_outputs: got %h want %h", o, e); end
        n_tests++;
        if (ifa.instr_count !== 32'd0 || ifb.instr_count !== 4'd0) begin
            n_fail++; $display("FAIL reset_count: got %0d/%0d want 0", ifa.instr_count, ifb.instr_count);
        end
        next_cycle();
        Reset = 1'b1;
        exp_cnt = 0;
    endtask

    task automatic test_add();
        ov_t e, o;
        int  pulses;
        pulses = 0;
        apply_reset();
        opcode = OP_ADD;
        for (int c = 0; c < 5; c++) begin
            #1;
            case (c)
                0: e = if_vec(1'b1);
                1: e = base(ST_ID);
                2: e = with_alu(base(ST_EXE_AL), OP_ADD);
                3: begin
                    e = with_alu(base(ST_WB_AL), OP_ADD);
                    e.rgw = 1'b1; e.wrs = 1'b1; e.rdst = 2'b10; e.pcw = 1'b1;
                end
                default: e = if_vec(1'b1);
            endcase
            o = observe(); n_tests++;
            if (o !== e) begin n_fail++; $display("FAIL add_cycle%0d: got %h want %h", c, o, e); end
            if (o.pcw) pulses++;
            next_cycle();
        end
        n_tests++;
        if (pulses != 1 || ifa.instr_count !== 32'd1) begin
            n_fail++; $display("FAIL add_retire: pulses %0d count %0d want 1/1", pulses, ifa.instr_count);
        end
    endtask

    task automatic test_lw_wait();
        ov_t e, o;
        int  pulses;
        pulses = 0;
        apply_reset();
        opcode = OP_LW;
        for (int c = 0; c < 8; c++) begin
            mem_ready = (c >= 3 && c <= 5) ? 1'b0 : 1'b1;
            #1;
            case (c)
                0: e = if_vec(1'b1);
                1: e = base(ST_ID);
                2: begin e = base(ST_EXE_LS); e.asb = 1'b1; e.ext = 1'b1; end
                3, 4, 5, 6: begin e = base(ST_MEM); e.nrd = 1'b0; end
                default: begin
                    e = base(ST_WB_LD);
                    e.rgw = 1'b1; e.dbs = 1'b1; e.rdst = 2'b01; e.wrs = 1'b1; e.pcw = 1'b1;
                end
            endcase
            o = observe(); n_tests++;
            if (o !== e) begin n_fail++; $display("FAIL lw_cycle%0d: got %h want %h", c, o, e); end
            if (o.pcw) pulses++;
            next_cycle();
        end
        n_tests++;
        if (pulses != 1 || ifa.instr_count !== 32'd1) begin
            n_fail++; $display("FAIL lw_retire: pulses %0d count %0d want 1/1", pulses, ifa.instr_count);
        end
    endtask

    task automatic test_branch();
        ov_t e, o;
        logic [5:0] bop;
        logic       tk;
        for (int t = 0; t < 6; t++) begin
            case (t)
                0: begin bop = OP_BEQ;  zero = 1'b1; sign = 1'b0; tk = 1'b1; end
                1: begin bop = OP_BEQ;  zero = 1'b0; sign = 1'b1; tk = 1'b0; end
                2: begin bop = OP_BNE;  zero = 1'b0; sign = 1'b0; tk = 1'b1; end
                3: begin bop = OP_BNE;  zero = 1'b1; sign = 1'b1; tk = 1'b0; end
                4: begin bop = OP_BLTZ; zero = 1'b0; sign = 1'b1; tk = 1'b1; end
                default: begin bop = OP_BLTZ; zero = 1'b1; sign = 1'b0; tk = 1'b0; end
            endcase
            opcode = bop; mem_ready = 1'b1;
            next_cycle();
            next_cycle();
            #1;
            e = base(ST_EXE_BR); e.aop = 3'b001; e.ext = 1'b1; e.pcw = 1'b1;
            e.pcs = tk ? 2'b01 : 2'b00;
            o = observe(); n_tests++;
            if (o !== e) begin n_fail++; $display("FAIL branch%0d op %b: got %h want %h", t, bop, o, e); end
            next_cycle();
        end
    endtask

    task automatic test_jumps();
        ov_t e, o;
        logic [5:0] jop;
        for (int t = 0; t < 3; t++) begin
            jop = (t == 0) ? OP_JAL : (t == 1) ? OP_J : OP_JR;
            opcode = jop; mem_ready = 1'b1;
            next_cycle();
            #1;
            e = base(ST_ID); e.pcw = 1'b1;
            e.pcs = (jop == OP_JR) ? 2'b10 : 2'b11;
            e.rgw = (jop == OP_JAL);
            o = observe(); n_tests++;
            if (o !== e) begin n_fail++; $display("FAIL jump%0d id: got %h want %h", t, o, e); end
            next_cycle();
            #1;
            e = if_vec(1'b1); o = observe(); n_tests++;
            if (o !== e) begin n_fail++; $display("FAIL jump%0d next: got %h want %h", t, o, e); end
        end
    endtask

    task automatic test_halt();
        ov_t e, o;
        apply_reset();
        opcode = OP_HALT;
        next_cycle();
        #1;
        e = base(ST_ID); o = observe(); n_tests++;
        if (o !== e) begin n_fail++; $display("FAIL halt_id: got %h want %h", o, e); end
        next_cycle();
        for (int c = 0; c < 20; c++) begin
            mem_ready = 1'($urandom_range(0, 1)); zero = 1'($urandom_range(0, 1));
            #1;
            e = base(3'b000); e.hlt = 1'b1;
            o = observe(); o.st = 3'b000;
            n_tests++;
            if (o !== e) begin n_fail++; $display("FAIL halt_hold%0d: got %h want %h", c, o, e); end
            next_cycle();
        end
        mem_ready = 1'b1;
        #1 Reset = 1'b0;
        #1;
        e = if_vec(1'b1); o = observe(); n_tests++;
        if (o !== e || ifa.instr_count !== 32'd0) begin
            n_fail++; $display("FAIL halt_reset: got %h cnt %0d want %h cnt 0", o, ifa.instr_count, e);
        end
        next_cycle();
        Reset = 1'b1;
        exp_cnt = 0;
    endtask

    task automatic test_wrap();
        apply_reset();
        mem_ready = 1'b1;
        for (int k = 0; k < 17; k++) begin
            opcode = OP_NOP | 6'(k % 4);
            next_cycle();
            next_cycle();
        end
        n_tests++;
        if (ifb.instr_count !== 4'd1 || ifa.instr_count !== 32'd17) begin
            n_fail++; $display("FAIL nop_wrap: got %0d/%0d want 1/17", ifb.instr_count, ifa.instr_count);
        end
    endtask

    task automatic test_sw_reset();
        ov_t e, o;
        apply_reset();
        opcode = OP_SW;
        next_cycle(); next_cycle(); next_cycle();
        mem_ready = 1'b0;
        #1;
        e = base(ST_MEM); e.nwr = 1'b0; o = observe(); n_tests++;
        if (o !== e) begin n_fail++; $display("FAIL sw_mem: got %h want %h", o, e); end
        #1 Reset = 1'b0;
        #1;
        e = if_vec(1'b0); o = observe(); n_tests++;
        if (o !== e) begin n_fail++; $display("FAIL sw_async_reset: got %h want %h", o, e); end
        next_cycle();
        Reset = 1'b1;
        exp_cnt = 0;
    endtask

    task automatic test_random();
        ov_t e, o;
        logic [5:0] op;
        logic       mr, tk;
        apply_reset();
        for (int k = 0; k < 150; k++) begin
            op = pick_op($urandom_range(0, 19));
            opcode = op;
            for (int w = 0; w < 6; w++) begin
                mr = (w == 5) ? 1'b1 : 1'($urandom_range(0, 1));
                mem_ready = mr; zero = 1'($urandom_range(0, 1)); sign = 1'($urandom_range(0, 1));
                #1;
                e = if_vec(mr); o = observe(); n_tests++;
                if (o !== e) begin n_fail++; $display("FAIL rand_if k%0d: got %h want %h", k, o, e); end
                next_cycle();
                if (mr) break;
            end
            #1;
            e = base(ST_ID);
            if (op == OP_J || op == OP_JR || op == OP_JAL) begin
                e.pcw = 1'b1; e.pcs = (op == OP_JR) ? 2'b10 : 2'b11; e.rgw = (op == OP_JAL);
            end else if (!is_alu(op) && op != OP_SW && op != OP_LW &&
                         op != OP_BEQ && op != OP_BNE && op != OP_BLTZ) begin
                e.pcw = 1'b1;
            end
            o = observe(); n_tests++;
            if (o !== e) begin n_fail++; $display("FAIL rand_id k%0d op %b: got %h want %h", k, op, o, e); end
            if (e.pcw) exp_cnt++;
            next_cycle();
            if (op == OP_BEQ || op == OP_BNE || op == OP_BLTZ) begin
                zero = 1'($urandom_range(0, 1)); sign = 1'($urandom_range(0, 1));
                #1;
                tk = (op == OP_BEQ) ? zero : (op == OP_BNE) ? !zero : sign;
                e = base(ST_EXE_BR); e.aop = 3'b001; e.ext = 1'b1; e.pcw = 1'b1; e.pcs = {1'b0, tk};
                o = observe(); n_tests++;
                if (o !== e) begin n_fail++; $display("FAIL rand_br k%0d: got %h want %h", k, o, e); end
                exp_cnt++;
                next_cycle();
            end else if (op == OP_SW || op == OP_LW) begin
                #1;
                e = base(ST_EXE_LS); e.asb = 1'b1; e.ext = 1'b1; o = observe(); n_tests++;
                if (o !== e) begin n_fail++; $display("FAIL rand_ls k%0d: got %h want %h", k, o, e); end
                next_cycle();
                for (int w = 0; w < 6; w++) begin
                    mr = (w == 5) ? 1'b1 : 1'($urandom_range(0, 1));
                    mem_ready = mr;
                    #1;
                    e = base(ST_MEM);
                    if (op == OP_SW) begin e.nwr = 1'b0; e.pcw = mr; end
                    else e.nrd = 1'b0;
                    o = observe(); n_tests++;
                    if (o !== e) begin n_fail++; $display("FAIL rand_mem k%0d: got %h want %h", k, o, e); end
                    if (e.pcw) exp_cnt++;
                    next_cycle();
                    if (mr) break;
                end
                if (op == OP_LW) begin
                    #1;
                    e = base(ST_WB_LD);
                    e.rgw = 1'b1; e.dbs = 1'b1; e.rdst = 2'b01; e.wrs = 1'b1; e.pcw = 1'b1;
                    o = observe(); n_tests++;
                    if (o !== e) begin n_fail++; $display("FAIL rand_wbld k%0d: got %h want %h", k, o, e); end
                    exp_cnt++;
                    next_cycle();
                end
            end else if (is_alu(op)) begin
                #1;
                e = with_alu(base(ST_EXE_AL), op); o = observe(); n_tests++;
                if (o !== e) begin n_fail++; $display("FAIL rand_exe k%0d op %b: got %h want %h", k, op, o, e); end
                next_cycle();
                #1;
                e = with_alu(base(ST_WB_AL), op);
                e.rgw = 1'b1; e.wrs = 1'b1; e.pcw = 1'b1; e.rdst = is_rt(op) ? 2'b10 : 2'b01;
                o = observe(); n_tests++;
                if (o !== e) begin n_fail++; $display("FAIL rand_wbal k%0d op %b: got %h want %h", k, op, o, e); end
                exp_cnt++;
                next_cycle();
            end
            n_tests++;
            if (ifa.instr_count !== exp_cnt || ifb.instr_count !== exp_cnt[3:0]) begin
                n_fail++;
                $display("FAIL rand_count k%0d: got %0d/%0d want %0d/%0d", k,
                         ifa.instr_count, ifb.instr_count, exp_cnt, exp_cnt[3:0]);
            end
        end
    endtask

    initial begin
        #1;
        test_reset();
        test_add();
        test_lw_wait();
        test_branch();
        test_jumps();
        test_halt();
        test_wrap();
        test_sw_reset();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, %0d tests run", n_tests);
        $fatal(1);
    end

endmodule
